// File: rtl/led_arb_pkg.sv
// Shared definitions for the two-master LED PIO arbiter: FSM state encoding,
// master index constants and default bus widths.
package led_arb_pkg;

    localparam int ADDR_W_DEF = 2;
    localparam int DATA_W_DEF = 32;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_t;

endpackage

// File: rtl/led_pio_arbiter_if.sv
// Avalon-MM style bus bundle (address/chipselect/write_n/writedata/readdata
// plus waitrequest). The same interface type serves the two upstream master
// ports and the downstream PIO port; the PIO port ignores waitrequest.
interface led_pio_arbiter_if
    import led_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] address;
    logic              chipselect;
    logic              write_n;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    // Requester side (Nios data master, voice-activity engine)
    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, waitrequest
    );

    // Arbiter side facing a requester
    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, waitrequest
    );

    // Arbiter side facing the LED PIO s1 port (no waitrequest on a PIO)
    modport pio (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

endinterface

// File: rtl/led_arb_pick.sv
// Combinational winner select for the two requesters.
// Optional build macro: LED_ARB_FIXED_PRIO_EN -- when defined, m0 always wins
// a tie; otherwise a tie goes to the master that was not granted last.
module led_arb_pick
    import led_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_idx
);

`ifdef LED_ARB_FIXED_PRIO_EN
    // last_grant is deliberately ignored in fixed-priority builds
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Pick the winner: a lone requester always wins; a tie is broken per build
    always_comb begin
        grant_valid = |req;
        grant_idx   = M0;
        if (req == 2'b10) begin
            grant_idx = M1;
        end else if (req == 2'b11) begin
`ifdef LED_ARB_FIXED_PRIO_EN
            grant_idx = M0;
`else
            grant_idx = ~last_grant;
`endif
        end
    end

endmodule

// File: rtl/led_pio_arbiter.sv
// Two-master arbiter serialising Avalon-MM accesses onto the single LED PIO.
// Every accepted access takes one grant cycle (IDLE) and one issue cycle
// (ISSUE) with registered PIO command signals, so the PIO sees at most one
// access per two cycles. Optional build macro: LED_ARB_FIXED_PRIO_EN (honoured
// in led_arb_pick) switches tie-breaking from round-robin to m0-first.
module led_pio_arbiter
    import led_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    led_pio_arbiter_if.slave  m0,
    led_pio_arbiter_if.slave  m1,
    led_pio_arbiter_if.pio    pio
);

    arb_state_t        state_reg, state_next;
    logic              last_grant_reg, last_grant_next;
    logic              winner_reg, winner_next;
    logic [1:0]        waitreq_reg, waitreq_next;
    logic              pio_cs_reg, pio_cs_next;
    logic              pio_write_n_reg, pio_write_n_next;
    logic [ADDR_W-1:0] pio_address_reg, pio_address_next;
    logic [DATA_W-1:0] pio_writedata_reg, pio_writedata_next;

    logic [1:0]        req;
    logic              grant_valid;
    logic              grant_idx;

    assign req = {m1.chipselect, m0.chipselect};

    led_arb_pick u_pick (
        .req         (req),
        .last_grant  (last_grant_reg),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    // State register; reset drops any in-flight transfer without a late ack
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: a grant always leads to exactly one ISSUE cycle
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = ISSUE;
            ISSUE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; command fields are sampled only
    // on the grant edge, so later changes on a held request are ignored
    always_comb begin
        last_grant_next    = last_grant_reg;
        winner_next        = winner_reg;
        waitreq_next       = waitreq_reg;
        pio_cs_next        = pio_cs_reg;
        pio_write_n_next   = pio_write_n_reg;
        pio_address_next   = pio_address_reg;
        pio_writedata_next = pio_writedata_reg;
        case (state_reg)
            IDLE: begin
                if (grant_valid) begin
                    winner_next        = grant_idx;
                    pio_cs_next        = 1'b1;
                    pio_address_next   = (grant_idx == M1) ? m1.address   : m0.address;
                    pio_write_n_next   = (grant_idx == M1) ? m1.write_n   : m0.write_n;
                    pio_writedata_next = (grant_idx == M1) ? m1.writedata : m0.writedata;
                    waitreq_next       = (grant_idx == M1) ? 2'b01 : 2'b10;
                end else begin
                    pio_cs_next      = 1'b0;
                    pio_write_n_next = 1'b1;
                end
            end
            ISSUE: begin
                pio_cs_next      = 1'b0;
                pio_write_n_next = 1'b1;
                waitreq_next     = 2'b11;
                last_grant_next  = winner_reg;
            end
            default: begin
                pio_cs_next      = 1'b0;
                pio_write_n_next = 1'b1;
                waitreq_next     = 2'b11;
            end
        endcase
    end

    // Datapath registers: PIO command, per-master waitrequest, grant history
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_reg    <= M1;
            winner_reg        <= M0;
            waitreq_reg       <= 2'b11;
            pio_cs_reg        <= 1'b0;
            pio_write_n_reg   <= 1'b1;
            pio_address_reg   <= '0;
            pio_writedata_reg <= '0;
        end else begin
            last_grant_reg    <= last_grant_next;
            winner_reg        <= winner_next;
            waitreq_reg       <= waitreq_next;
            pio_cs_reg        <= pio_cs_next;
            pio_write_n_reg   <= pio_write_n_next;
            pio_address_reg   <= pio_address_next;
            pio_writedata_reg <= pio_writedata_next;
        end
    end

    assign pio.chipselect = pio_cs_reg;
    assign pio.write_n    = pio_write_n_reg;
    assign pio.address    = pio_address_reg;
    assign pio.writedata  = pio_writedata_reg;

    assign m0.waitrequest = waitreq_reg[0];
    assign m1.waitrequest = waitreq_reg[1];

    // Only the granted master sees PIO read data, and only while issuing
    assign m0.readdata = (state_reg == ISSUE && winner_reg == M0) ? pio.readdata : '0;
    assign m1.readdata = (state_reg == ISSUE && winner_reg == M1) ? pio.readdata : '0;

endmodule

// File: tb/tb_led_pio_arbiter.sv
// Directed bench for led_pio_arbiter with a behavioural 8-bit LED PIO model.
// Expectations follow the round-robin build unless LED_ARB_FIXED_PRIO_EN is set.
module tb_led_pio_arbiter;

    logic clk;
    logic reset_n;
    logic [7:0] led;
    int n_cmp = 0;
    int n_err = 0;

    led_pio_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m0_bus ();
    led_pio_arbiter_if #(.ADDR_W(2), .DATA_W(32)) m1_bus ();
    led_pio_arbiter_if #(.ADDR_W(2), .DATA_W(32)) pio_bus ();

    led_pio_arbiter #(.ADDR_W(2), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .m0      (m0_bus),
        .m1      (m1_bus),
        .pio     (pio_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // LED PIO model: register at address 0, combinational read
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led <= 8'h00;
        end else if (pio_bus.chipselect && !pio_bus.write_n && pio_bus.address == 2'd0) begin
            led <= pio_bus.writedata[7:0];
        end
    end
    assign pio_bus.readdata    = (pio_bus.address == 2'd0) ? {24'h0, led} : 32'h0;
    assign pio_bus.waitrequest = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        logic exp_m0;
        logic exp_m1;
        logic is_issue;
        int   tr;

        reset_n = 1'b0;
        m0_bus.address = 2'd0; m0_bus.chipselect = 1'b0; m0_bus.write_n = 1'b1; m0_bus.writedata = 32'h0;
        m1_bus.address = 2'd0; m1_bus.chipselect = 1'b0; m1_bus.write_n = 1'b1; m1_bus.writedata = 32'h0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        #1;

        // Reset state
        chk("rst_pio_cs",   32'(pio_bus.chipselect), 32'd0);
        chk("rst_pio_wn",   32'(pio_bus.write_n),    32'd1);
        chk("rst_pio_addr", 32'(pio_bus.address),    32'd0);
        chk("rst_pio_wd",   pio_bus.writedata,       32'd0);
        chk("rst_m0_wait",  32'(m0_bus.waitrequest), 32'd1);
        chk("rst_m1_wait",  32'(m1_bus.waitrequest), 32'd1);
        chk("rst_m0_rd",    m0_bus.readdata,         32'd0);
        chk("rst_m1_rd",    m1_bus.readdata,         32'd0);

        // m0 writes 0xA5 to address 0
        tick();
        m0_bus.chipselect = 1'b1; m0_bus.write_n = 1'b0; m0_bus.writedata = 32'h0000_00A5;
        #1 chk("t1_wait_req_cycle", 32'(m0_bus.waitrequest), 32'd1);
        tick();
        chk("t1_m0_wait_low", 32'(m0_bus.waitrequest), 32'd0);
        chk("t1_m1_wait",     32'(m1_bus.waitrequest), 32'd1);
        chk("t1_pio_cs",      32'(pio_bus.chipselect), 32'd1);
        chk("t1_pio_wn",      32'(pio_bus.write_n),    32'd0);
        chk("t1_pio_wd",      pio_bus.writedata,       32'h0000_00A5);
        m0_bus.writedata = 32'h0000_00FF;  // must be ignored: sampled only at grant
        tick();
        chk("t1_m0_wait_back", 32'(m0_bus.waitrequest), 32'd1);
        chk("t1_pio_cs_off",   32'(pio_bus.chipselect), 32'd0);
        chk("t1_pio_wn_off",   32'(pio_bus.write_n),    32'd1);
        chk("t1_pio_wd_keep",  pio_bus.writedata,       32'h0000_00A5);
        chk("t1_led",          32'(led),                32'h0000_00A5);
        $display("xfer m0 write 0x%02h -> led 0x%02h", 8'hA5, led);
        m0_bus.chipselect = 1'b0;

        // m0 sets LEDs to 0x3C, then m1 reads them back
        m0_bus.chipselect = 1'b1; m0_bus.write_n = 1'b0; m0_bus.writedata = 32'h0000_003C;
        tick();
        tick();
        m0_bus.chipselect = 1'b0;
        chk("t2_led", 32'(led), 32'h0000_003C);
        m1_bus.chipselect = 1'b1; m1_bus.write_n = 1'b1; m1_bus.address = 2'd0;
        tick();
        chk("t2_m1_wait_low", 32'(m1_bus.waitrequest), 32'd0);
        chk("t2_m0_wait",     32'(m0_bus.waitrequest), 32'd1);
        chk("t2_m1_rd",       m1_bus.readdata,         32'h0000_003C);
        chk("t2_m0_rd",       m0_bus.readdata,         32'h0000_0000);
        chk("t2_pio_wn",      32'(pio_bus.write_n),    32'd1);
        $display("xfer m1 read -> 0x%08h", m1_bus.readdata);
        tick();
        chk("t2_m1_rd_after", m1_bus.readdata, 32'h0);
        m1_bus.chipselect = 1'b0;

        // Both masters stream writes: 8 transfers over 16 cycles
        m0_bus.chipselect = 1'b1; m0_bus.write_n = 1'b0; m0_bus.writedata = 32'h1; m0_bus.address = 2'd0;
        m1_bus.chipselect = 1'b1; m1_bus.write_n = 1'b0; m1_bus.writedata = 32'h2; m1_bus.address = 2'd0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            is_issue = (k % 2) == 1;
            tr = (k - 1) / 2;
`ifdef LED_ARB_FIXED_PRIO_EN
            exp_m0 = is_issue;
            exp_m1 = 1'b0;
`else
            exp_m0 = is_issue && (tr % 2 == 0);
            exp_m1 = is_issue && (tr % 2 == 1);
`endif
            chk($sformatf("t3_m0_wait_c%0d", k), 32'(m0_bus.waitrequest), 32'(!exp_m0));
            chk($sformatf("t3_m1_wait_c%0d", k), 32'(m1_bus.waitrequest), 32'(!exp_m1));
            if (is_issue) begin
                chk($sformatf("t3_pio_wd_c%0d", k), pio_bus.writedata, exp_m0 ? 32'h1 : 32'h2);
                $display("xfer %0d stream write data 0x%0h", tr, pio_bus.writedata);
            end
        end
        m0_bus.chipselect = 1'b0;
        m1_bus.chipselect = 1'b0;

        // m1 alone, m0 arrives during m1's ISSUE
        m1_bus.chipselect = 1'b1; m1_bus.write_n = 1'b1; m1_bus.address = 2'd0;
        tick();
        m0_bus.chipselect = 1'b1; m0_bus.write_n = 1'b0; m0_bus.writedata = 32'h55;
        #1;
        chk("t4_m1_wait_low", 32'(m1_bus.waitrequest), 32'd0);
        chk("t4_m0_wait",     32'(m0_bus.waitrequest), 32'd1);
        tick();
        m1_bus.chipselect = 1'b0;
        chk("t4_idle_m0_wait", 32'(m0_bus.waitrequest), 32'd1);
        chk("t4_idle_m1_wait", 32'(m1_bus.waitrequest), 32'd1);
        chk("t4_idle_pio_cs",  32'(pio_bus.chipselect), 32'd0);
        tick();
        chk("t4_m0_wait_low", 32'(m0_bus.waitrequest), 32'd0);
        chk("t4_pio_cs",      32'(pio_bus.chipselect), 32'd1);
        chk("t4_pio_wd",      pio_bus.writedata,       32'h55);
        tick();
        m0_bus.chipselect = 1'b0;
        chk("t4_led", 32'(led), 32'h55);
        $display("xfer m1 read then m0 write 0x55 -> led 0x%02h", led);

        // Reset pulsed during ISSUE
        m0_bus.chipselect = 1'b1; m0_bus.write_n = 1'b0; m0_bus.writedata = 32'h77;
        tick();
        chk("t5_m0_wait_low", 32'(m0_bus.waitrequest), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        chk("t5_rst_pio_cs",  32'(pio_bus.chipselect), 32'd0);
        chk("t5_rst_m0_wait", 32'(m0_bus.waitrequest), 32'd1);
        chk("t5_rst_m1_wait", 32'(m1_bus.waitrequest), 32'd1);
        chk("t5_rst_m0_rd",   m0_bus.readdata,         32'd0);
        chk("t5_rst_pio_wn",  32'(pio_bus.write_n),    32'd1);
        m0_bus.chipselect = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("t5_post_m0_wait", 32'(m0_bus.waitrequest), 32'd1);
        chk("t5_post_pio_cs",  32'(pio_bus.chipselect), 32'd0);
        m0_bus.chipselect = 1'b1; m0_bus.write_n = 1'b0; m0_bus.writedata = 32'h99;
        #1 chk("t5_new_req_wait", 32'(m0_bus.waitrequest), 32'd1);
        tick();
        chk("t5_new_wait_low", 32'(m0_bus.waitrequest), 32'd0);
        chk("t5_new_pio_cs",   32'(pio_bus.chipselect), 32'd1);
        chk("t5_new_pio_wd",   pio_bus.writedata,       32'h99);
        tick();
        m0_bus.chipselect = 1'b0;
        chk("t5_new_wait_back", 32'(m0_bus.waitrequest), 32'd1);
        chk("t5_new_led",       32'(led),                32'h99);
        $display("xfer m0 write 0x99 after reset -> led 0x%02h", led);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
